// File: rtl/instr_queue.sv
// Instruction queue between the fetch re-aligner and decode: a DEPTH-entry FIFO of
// {instr, pc, compressed} with ready/valid on both sides and a single-cycle flush.
module instr_queue #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [31:0]      instr_i,
    input  logic [31:0]      pc_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [31:0]      instr_o,
    output logic [31:0]      pc_o,
    output logic             compressed_o,
    input  logic             ready_i,
    output logic [PTR_W:0]   count_o
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        compressed;
    } entry_t;

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

    // An RVC encoding is anything whose two low bits are not both set.
    function automatic logic is_compressed(input logic [1:0] low_bits);
        return ~&low_bits;
    endfunction

    entry_t           mem_r [DEPTH];
    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] rptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_s;
    logic             pop_s;
    entry_t           head_s;

    // Handshake qualifiers; a full queue refuses a push even when a pop is in flight.
    always_comb begin
        ready_o = (count_r != CNT_FULL);
        valid_o = (count_r != CNT_ZERO);
        push_s  = valid_i & ready_o;
        pop_s   = valid_o & ready_i;
    end

    // Entry storage: cleared only by reset, never by flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s && !flush_i) begin
            mem_r[wptr_r] <= '{instr: instr_i, pc: pc_i, compressed: is_compressed(instr_i[1:0])};
        end
    end

    // Pointer and occupancy bookkeeping; flush overrides any push or pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_r  <= PTR_ZERO;
            rptr_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else if (flush_i) begin
            wptr_r  <= PTR_ZERO;
            rptr_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head entry goes straight to decode; stale when valid_o is low.
    always_comb begin
        head_s       = mem_r[rptr_r];
        instr_o      = head_s.instr;
        pc_o         = head_s.pc;
        compressed_o = head_s.compressed;
        count_o      = count_r;
    end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: directed stimulus queues expected entries,
// a negedge monitor checks every entry decode consumes.
module tb_instr_queue;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        compressed;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        valid_i;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        compressed_o;
    logic        ready_i;
    logic [2:0]  count_o;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    instr_queue #(.DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
        .instr_i(instr_i), .pc_i(pc_i), .ready_o(ready_o), .valid_o(valid_o),
        .instr_o(instr_o), .pc_o(pc_o), .compressed_o(compressed_o),
        .ready_i(ready_i), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: a pop happens at the next edge whenever valid_o & ready_i here.
    always @(negedge clk_i) begin
        if (rst_ni && !flush_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop_pc", {40'd0, pc_o}, 72'hFFFF_FFFF_FFFF_FFFF_FF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pop_entry", {7'd0, instr_o, pc_o, compressed_o},
                    {7'd0, e.instr, e.pc, e.compressed});
            end
        end
    end

    function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc);
        return '{instr: instr, pc: pc, compressed: (instr[1:0] != 2'b11)};
    endfunction

    // Called at posedge+1; returns at the following posedge+1 with valid_i low.
    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input bit accept);
        valid_i = 1'b1;
        instr_i = instr;
        pc_i    = pc;
        if (accept) exp_q.push_back(mk(instr, pc));
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        instr_i = 32'd0; pc_i = 32'd0;

        // Reset held for three cycles, then released
        cycles(3);
        chk("rst_hold_flags", {69'd0, valid_o, ready_o, compressed_o}, {69'd0, 1'b0, 1'b1, 1'b0});
        chk("rst_hold_count", {69'd0, count_o}, 72'd0);
        rst_ni = 1'b1;
        cycles(1);
        chk("rst_rel_flags", {69'd0, valid_o, ready_o, compressed_o}, {69'd0, 1'b0, 1'b1, 1'b0});
        chk("rst_rel_count", {69'd0, count_o}, 72'd0);
        chk("rst_rel_data", {8'd0, instr_o, pc_o}, 72'd0);

        // Fill with decode stalled, then drain in order
        push(32'h0000_0013, 32'h0, 1'b1);
        push(32'h0000_4501, 32'h4, 1'b1);
        push(32'h00A0_0093, 32'h6, 1'b1);
        push(32'h0000_8082, 32'hA, 1'b1);
        chk("full_count", {69'd0, count_o}, 72'd4);
        chk("full_ready", {71'd0, ready_o}, 72'd0);
        chk("full_head", {40'd0, instr_o}, {40'd0, 32'h0000_0013});
        push(32'h0000_0033, 32'hE, 1'b0);
        chk("drop5_count", {69'd0, count_o}, 72'd4);
        ready_i = 1'b1;
        cycles(4);
        chk("drain_valid", {71'd0, valid_o}, 72'd0);
        chk("drain_count", {69'd0, count_o}, 72'd0);
        chk("drain_sb_empty", 72'(exp_q.size()), 72'd0);

        // Full queue with simultaneous pop: push refused, count drops to 3
        ready_i = 1'b0;
        push(32'h0000_0113, 32'h20, 1'b1);
        push(32'h0000_4185, 32'h22, 1'b1);
        push(32'h0000_0193, 32'h24, 1'b1);
        push(32'h0000_0213, 32'h28, 1'b1);
        ready_i = 1'b1;
        push(32'h0000_0293, 32'h2C, 1'b0);
        ready_i = 1'b0;
        chk("fullpop_count", {69'd0, count_o}, 72'd3);
        chk("fullpop_ready", {71'd0, ready_o}, 72'd1);
        ready_i = 1'b1;
        cycles(3);
        chk("fullpop_drain", {69'd0, count_o}, 72'd0);

        // Streaming across the pointer wrap
        for (int k = 0; k < 10; k++) begin
            valid_i = 1'b1;
            instr_i = k[0] ? 32'h0000_4501 + (32'(k) << 16) : 32'h0000_0013 + (32'(k) << 20);
            pc_i    = 32'h100 + 32'(4 * k);
            exp_q.push_back(mk(instr_i, pc_i));
            @(posedge clk_i); #1;
            chk("stream_count", {69'd0, count_o}, 72'd1);
        end
        valid_i = 1'b0;
        cycles(1);
        chk("stream_end_count", {69'd0, count_o}, 72'd0);
        chk("stream_sb_empty", 72'(exp_q.size()), 72'd0);

        // Flush with a same-cycle push: the push is discarded
        ready_i = 1'b0;
        push(32'h0000_0313, 32'h300, 1'b1);
        push(32'h0000_0393, 32'h304, 1'b1);
        push(32'h0000_0413, 32'h308, 1'b1);
        chk("preflush_count", {69'd0, count_o}, 72'd3);
        exp_q.delete();
        flush_i = 1'b1;
        push(32'h0000_0493, 32'h200, 1'b0);
        flush_i = 1'b0;
        chk("flush_count", {69'd0, count_o}, 72'd0);
        chk("flush_flags", {70'd0, valid_o, ready_o}, {70'd0, 1'b0, 1'b1});
        ready_i = 1'b1;
        push(32'h0000_0513, 32'h400, 1'b1);
        cycles(2);
        chk("postflush_sb_empty", 72'(exp_q.size()), 72'd0);
        chk("postflush_count", {69'd0, count_o}, 72'd0);

        // Asynchronous reset between edges
        ready_i = 1'b0;
        push(32'h0000_0593, 32'h500, 1'b1);
        push(32'h0000_4601, 32'h504, 1'b1);
        chk("prerst_count", {69'd0, count_o}, 72'd2);
        @(negedge clk_i); #2;
        exp_q.delete();
        rst_ni = 1'b0;
        #1;
        chk("async_rst_valid", {71'd0, valid_o}, 72'd0);
        chk("async_rst_count", {69'd0, count_o}, 72'd0);
        chk("async_rst_data", {7'd0, instr_o, pc_o, compressed_o}, 72'd0);
        cycles(1);
        rst_ni = 1'b1;
        cycles(1);
        chk("after_rst_ready", {71'd0, ready_o}, 72'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
